xgmii_tx_pacer: RTL and testbench

- Sits in the tx_user_clk domain between the MAC-side XGMII source and the PCS XGMII transmit input (xgmii_txd_i, xgmii_txc_i, xgmii_txd_vld_i).
- Accepts 64-bit XGMII words over a valid/ready handshake and buffers them in a small FIFO.
- Presents one word every other cycle with a strict alternating valid strobe, matching the PCS 312.5 MHz, half-rate data cadence.
- Fills FIFO underflow with Idle, or with Error followed by a frame drop when the underflow falls inside a frame.

---
 rtl/xgmii_pkg.sv | 67 ++++++
 rtl/xgmii_sync_fifo.sv | 58 +++++
 rtl/xgmii_tx_pacer.sv | 202 ++++++++++++++++++++
 tb/tb_xgmii_tx_pacer.sv | 582 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// XGMII shared definitions: control codes, canned Idle/Error words,
// lane decode helpers and the pacer state encoding.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
    localparam logic [63:0] ERROR_WORD = {8{XGMII_ERROR}};
    localparam logic [7:0]  CTRL_ALL   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DROP     = 2'd2
    } pacer_state_t;

    function automatic logic lane_is(
        input logic [63:0] d,
        input logic [7:0]  c,
        input logic [2:0]  lane,
        input logic [7:0]  code
    );
        return c[lane] && (d[{lane, 3'b000} +: 8] == code);
    endfunction

    function automatic logic has_start(
        input logic [63:0] d,
        input logic [7:0]  c
    );
        return lane_is(d, c, 3'd0, XGMII_START) ||
               lane_is(d, c, 3'd4, XGMII_START);
    endfunction

    function automatic logic has_term(
        input logic [63:0] d,
        input logic [7:0]  c
    );
        logic r;
        r = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r = r | lane_is(d, c, 3'(k), XGMII_TERM);
        end
        return r;
    endfunction

    // True when a Terminate sits in a lane above the Start lane, i.e.
    // the frame opened by this word is also closed by it.
    function automatic logic term_after_start(
        input logic [63:0] d,
        input logic [7:0]  c
    );
        logic r;
        int   first;
        r     = 1'b0;
        first = lane_is(d, c, 3'd0, XGMII_START) ? 1 : 5;
        for (int k = 0; k < 8; k++) begin
            if (k >= first) begin
                r = r | lane_is(d, c, 3'(k), XGMII_TERM);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xgmii_sync_fifo.sv
// Single-clock FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports: clk_i, rst_i (sync, active-high), push_i/wdata_i, pop_i/rdata_o
// (head word, valid while !empty_o), full_o, empty_o, count_o.
module xgmii_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != (AW+1)'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/xgmii_tx_pacer.sv
// XGMII TX pacer: buffers upstream words and presents one word every
// other cycle to the PCS with an alternating strobe; underflow inside a
// frame emits Error then drops the rest of that frame.
// Ports: tx_user_clk_i, tx_user_rst_i (sync, active-high);
//   s_txd_i/s_txc_i/s_valid_i/s_ready_o upstream handshake;
//   xgmii_txd_o/xgmii_txc_o/xgmii_txd_vld_o to PCS;
//   underflow_o, protocol_err_o one-cycle pulses.
// Macro XGMII_TX_PACER_STATS_EN adds frame_cnt_o and underflow_cnt_o.
module xgmii_tx_pacer
    import xgmii_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic        tx_user_clk_i,
    input  logic        tx_user_rst_i,
    input  logic [63:0] s_txd_i,
    input  logic [7:0]  s_txc_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [63:0] xgmii_txd_o,
    output logic [7:0]  xgmii_txc_o,
    output logic        xgmii_txd_vld_o,
    output logic        underflow_o,
    output logic        protocol_err_o
`ifdef XGMII_TX_PACER_STATS_EN
    ,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] underflow_cnt_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [71:0]   fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   count_nxt;

    logic          push, pop, load;
    logic [63:0]   head_d;
    logic [7:0]    head_c;
    logic          head_start, head_term, head_opens;

    pacer_state_t  state_q, state_d;
    logic          phase_q, phase_d;
    logic [63:0]   txd_q, txd_d;
    logic [7:0]    txc_q, txc_d;
    logic          ready_q, ready_d;
    logic          ufl_q, ufl_d;
    logic          perr_q, perr_d;

    xgmii_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (72)
    ) u_fifo (
        .clk_i   (tx_user_clk_i),
        .rst_i   (tx_user_rst_i),
        .push_i  (push),
        .wdata_i ({s_txc_i, s_txd_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Output registers reload only when phase is low; the word is then
    // held through the strobe-high cycle and the following strobe-low one.
    assign load       = !phase_q;
    assign push       = s_valid_i && ready_q && !fifo_full;
    assign head_d     = fifo_rdata[63:0];
    assign head_c     = fifo_rdata[71:64];
    assign head_start = has_start(head_d, head_c);
    assign head_term  = has_term(head_d, head_c);
    assign head_opens = head_start && !term_after_start(head_d, head_c);

    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        txc_d   = txc_q;
        ufl_d   = 1'b0;
        perr_d  = 1'b0;
        pop     = 1'b0;
        phase_d = !phase_q;

        if (load) begin
            unique case (state_q)
                IDLE: begin
                    if (fifo_empty) begin
                        txd_d = IDLE_WORD;
                        txc_d = CTRL_ALL;
                    end else begin
                        pop   = 1'b1;
                        txd_d = head_d;
                        txc_d = head_c;
                        if (head_opens) begin
                            state_d = IN_FRAME;
                        end
                    end
                end
                IN_FRAME: begin
                    if (fifo_empty) begin
                        txd_d   = ERROR_WORD;
                        txc_d   = CTRL_ALL;
                        ufl_d   = 1'b1;
                        state_d = DROP;
                    end else begin
                        pop   = 1'b1;
                        txd_d = head_d;
                        txc_d = head_c;
                        if (head_term) begin
                            state_d = IDLE;
                        end else if (head_start) begin
                            perr_d = 1'b1;
                        end
                    end
                end
                DROP: begin
                    txd_d = IDLE_WORD;
                    txc_d = CTRL_ALL;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_term) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Ready looks at the occupancy after this edge, so a slot freed
        // by a pop is only offered upstream on the next cycle.
        count_nxt = {1'b0, fifo_count}
                  + (CW+1)'(push)
                  - (CW+1)'(pop);
        ready_d   = count_nxt < (CW+1)'(FIFO_DEPTH);
    end

    always_ff @(posedge tx_user_clk_i) begin
        if (tx_user_rst_i) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            txd_q   <= IDLE_WORD;
            txc_q   <= CTRL_ALL;
            ready_q <= 1'b0;
            ufl_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
            ready_q <= ready_d;
            ufl_q   <= ufl_d;
            perr_q  <= perr_d;
        end
    end

    assign s_ready_o       = ready_q;
    assign xgmii_txd_o     = txd_q;
    assign xgmii_txc_o     = txc_q;
    assign xgmii_txd_vld_o = phase_q;
    assign underflow_o     = ufl_q;
    assign protocol_err_o  = perr_q;

`ifdef XGMII_TX_PACER_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] underflow_cnt_q, underflow_cnt_d;
    logic             frame_inc;

    always_comb begin
        frame_inc = load && (state_q == IDLE) && !fifo_empty && head_start;
        frame_cnt_d     = frame_cnt_q;
        underflow_cnt_d = underflow_cnt_q;
        if (frame_inc && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (ufl_d && (underflow_cnt_q != '1)) begin
            underflow_cnt_d = underflow_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge tx_user_clk_i) begin
        if (tx_user_rst_i) begin
            frame_cnt_q     <= '0;
            underflow_cnt_q <= '0;
        end else begin
            frame_cnt_q     <= frame_cnt_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign frame_cnt_o     = frame_cnt_q;
    assign underflow_cnt_o = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_xgmii_tx_pacer.sv
// Self-checking bench for xgmii_tx_pacer: directed scenarios plus
// randomized frames against a queue-based reference model.
`timescale 1ns/1ps
module tb_xgmii_tx_pacer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_txd;
    logic [7:0]  s_txc;
    logic        s_valid;
    logic        ready;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        vld;
    logic        ufl;
    logic        perr;
`ifdef XGMII_TX_PACER_STATS_EN
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] ufl_cnt;
`endif

    always #5 clk = ~clk;

    xgmii_tx_pacer #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .tx_user_clk_i   (clk),
        .tx_user_rst_i   (rst),
        .s_txd_i         (s_txd),
        .s_txc_i         (s_txc),
        .s_valid_i       (s_valid),
        .s_ready_o       (ready),
        .xgmii_txd_o     (txd),
        .xgmii_txc_o     (txc),
        .xgmii_txd_vld_o (vld),
        .underflow_o     (ufl),
        .protocol_err_o  (perr)
`ifdef XGMII_TX_PACER_STATS_EN
        ,
        .frame_cnt_o     (frame_cnt),
        .underflow_cnt_o (ufl_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pct    = 0;
    logic [71:0] src [$];

    // Reference model state
    logic [71:0]      m_q [$];
    int               m_mode;
    bit               m_phase, m_ready, m_ufl, m_perr;
    logic [63:0]      m_txd;
    logic [7:0]       m_txc;
    logic [CNT_W-1:0] m_frames, m_ufls;

    function automatic bit lane_is(logic [71:0] w, int k, logic [7:0] code);
        logic [63:0] d;
        logic [7:0]  c;
        d = w[63:0];
        c = w[71:64];
        return c[k] && (d[8*k +: 8] == code);
    endfunction

    function automatic int start_lane(logic [71:0] w);
        if (lane_is(w, 0, 8'hFB)) return 0;
        if (lane_is(w, 4, 8'hFB)) return 4;
        return -1;
    endfunction

    function automatic int last_term(logic [71:0] w);
        int r;
        r = -1;
        for (int k = 0; k < 8; k++) if (lane_is(w, k, 8'hFD)) r = k;
        return r;
    endfunction

    function automatic logic [71:0] mk_data();
        return {8'h00, $urandom, $urandom};
    endfunction

    function automatic logic [71:0] mk_start(bit lane4);
        logic [63:0] d;
        logic [7:0]  c;
        d = {$urandom, $urandom};
        if (!lane4) begin
            d[7:0] = 8'hFB;
            c      = 8'h01;
        end else begin
            d[31:0]  = 32'h07070707;
            d[39:32] = 8'hFB;
            c        = 8'h1F;
        end
        return {c, d};
    endfunction

    function automatic logic [71:0] mk_term(int k);
        logic [63:0] d;
        logic [7:0]  c;
        d = {$urandom, $urandom};
        c = 8'h00;
        d[8*k +: 8] = 8'hFD;
        c[k] = 1'b1;
        for (int j = k + 1; j < 8; j++) begin
            d[8*j +: 8] = 8'h07;
            c[j] = 1'b1;
        end
        return {c, d};
    endfunction

    function automatic logic [71:0] mk_single();
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[7:0]   = 8'hFB;
        d[39:32] = 8'hFD;
        d[63:40] = 24'h070707;
        return {8'hF1, d};
    endfunction

    // Terminate in lane 2 closes a frame, Start in lane 4 opens the next.
    function automatic logic [71:0] mk_tail_start();
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[23:16] = 8'hFD;
        d[31:24] = 8'h07;
        d[39:32] = 8'hFB;
        return {8'h1C, d};
    endfunction

    function automatic logic [75:0] exp_vec();
        return {m_phase, m_txd, m_txc, m_ready, m_ufl, m_perr};
    endfunction

    function automatic logic [75:0] act_vec();
        return {vld, txd, txc, ready, ufl, perr};
    endfunction

    task automatic model_step();
        logic [71:0] w;
        bit push;
        int st, lt;
        if (rst) begin
            m_q.delete();
            m_mode = 0;  m_phase = 0; m_ready = 0;
            m_txd = IDLE_W; m_txc = 8'hFF;
            m_ufl = 0;   m_perr = 0;
            m_frames = '0; m_ufls = '0;
            return;
        end
        push   = s_valid && m_ready;
        m_ufl  = 0;
        m_perr = 0;
        if (!m_phase) begin
            if (m_q.size() == 0) begin
                m_txd = IDLE_W;
                m_txc = 8'hFF;
                if (m_mode == 1) begin
                    m_txd  = ERR_W;
                    m_ufl  = 1;
                    m_mode = 2;
                end
            end else begin
                w  = m_q.pop_front();
                st = start_lane(w);
                lt = last_term(w);
                if (m_mode == 2) begin
                    m_txd = IDLE_W;
                    m_txc = 8'hFF;
                    if (lt >= 0) m_mode = 0;
                end else begin
                    m_txd = w[63:0];
                    m_txc = w[71:64];
                    if (m_mode == 0) begin
                        if (st >= 0) begin
                            if (m_frames != '1) m_frames = m_frames + 1;
                            if (lt < st) m_mode = 1;
                        end
                    end else if (lt >= 0) begin
                        m_mode = 0;
                    end else if (st >= 0) begin
                        m_perr = 1;
                    end
                end
            end
        end
        if (push) begin
            m_q.push_back({s_txc, s_txd});
            if (src.size() > 0) void'(src.pop_front());
        end
        m_phase = !m_phase;
        m_ready = m_q.size() < DEPTH;
        if (m_ufl && m_ufls != '1) m_ufls = m_ufls + 1;
    endtask

    task automatic present();
        if (src.size() > 0 && $urandom_range(99) < pct) begin
            s_valid = 1'b1;
            s_txd   = src[0][63:0];
            s_txc   = src[0][71:64];
        end else begin
            s_valid = 1'b0;
            s_txd   = {$urandom, $urandom};
            s_txc   = 8'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        present();
    endtask

    function automatic bit is_filler();
        return txc == 8'hFF && (txd == IDLE_W || txd == ERR_W);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        pct = 0;
        s_valid = 1'b0;
        s_txd = '0;
        s_txc = '0;
        repeat (3) begin
            step();
            checks++;
            if (act_vec() !== {1'b0, IDLE_W, 8'hFF, 3'b000}) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, act_vec(),
                         {1'b0, IDLE_W, 8'hFF, 3'b000});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic prev;
        pct  = 0;
        prev = vld;
        repeat (20) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            checks++;
            if (vld === prev || txd !== IDLE_W || txc !== 8'hFF || ufl || perr) begin
                errors++;
                $display("FAIL idle_cadence cyc=%0d vld=%b prev=%b txd=%h txc=%h",
                         cyc, vld, prev, txd, txc);
            end
            prev = vld;
        end
    endtask

    task automatic test_frame();
        logic [71:0] exp_w [$];
        logic [71:0] got [$];
        exp_w = '{mk_start(0), mk_data(), mk_data(), mk_term(0)};
        src = exp_w;
        pct = 100;
        repeat (16) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL frame cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (vld && !is_filler()) got.push_back({txc, txd});
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL frame_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL frame_word%0d got=%h exp=%h", i, got[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit saw_full;
        saw_full = 0;
        for (int f = 0; f < 4; f++) begin
            src.push_back(mk_start(0));
            src.push_back(mk_data());
            src.push_back(mk_data());
            src.push_back(mk_term(3));
        end
        pct = 100;
        for (int i = 0; i < 200 && src.size() > 0; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (!ready) saw_full = 1;
        end
        checks++;
        if (src.size() != 0 || !saw_full) begin
            errors++;
            $display("FAIL b2b_fill left=%0d saw_not_ready=%0d exp 0/1", src.size(), saw_full);
        end
        repeat (12) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_tail cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_underflow();
        logic [71:0] late;
        logic [71:0] exp_w [$];
        logic [71:0] got [$];
        int n_err, n_ufl, n_late;
        n_err = 0; n_ufl = 0; n_late = 0;
        exp_w = '{mk_start(0), mk_data(), mk_start(0), mk_data(), mk_term(1)};
        late  = mk_term(3);
        src = '{exp_w[0], exp_w[1]};
        pct = 100;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 1) src.push_back(late);
            if (ph == 2) src = '{exp_w[2], exp_w[3], exp_w[4]};
            for (int i = 0; i < 60 && src.size() > 0; i++) begin
                step();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL underflow cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
                end
                if (vld && txd == ERR_W && txc == 8'hFF) n_err++;
                if (ufl) n_ufl++;
                if (vld && {txc, txd} == late) n_late++;
                if (vld && !is_filler()) got.push_back({txc, txd});
            end
            repeat (ph == 0 ? 6 : 12) begin
                step();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL underflow cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
                end
                if (vld && txd == ERR_W && txc == 8'hFF) n_err++;
                if (ufl) n_ufl++;
                if (vld && {txc, txd} == late) n_late++;
                if (vld && !is_filler()) got.push_back({txc, txd});
            end
        end
        checks++;
        if (n_err != 1 || n_ufl != 1 || n_late != 0) begin
            errors++;
            $display("FAIL underflow_events err=%0d ufl=%0d late=%0d exp 1/1/0", n_err, n_ufl, n_late);
        end
        checks++;
        if (got != exp_w) begin
            errors++;
            $display("FAIL underflow_words got=%0d words exp=%0d in order", got.size(), exp_w.size());
        end
    endtask

    task automatic test_protocol_err();
        logic [71:0] exp_w [$];
        logic [71:0] got [$];
        logic [71:0] perr_w;
        int n_perr;
        n_perr = 0;
        perr_w = '0;
        exp_w = '{mk_start(0), mk_data(), mk_start(1), mk_data(), mk_term(2)};
        src = exp_w;
        pct = 100;
        repeat (24) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL perr cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (perr) begin
                n_perr++;
                perr_w = {txc, txd};
            end
            if (vld && !is_filler()) got.push_back({txc, txd});
        end
        checks++;
        if (n_perr != 1 || perr_w !== exp_w[2]) begin
            errors++;
            $display("FAIL perr_pulse n=%0d word=%h exp 1 word=%h", n_perr, perr_w, exp_w[2]);
        end
        checks++;
        if (got != exp_w) begin
            errors++;
            $display("FAIL perr_words got=%0d words exp=%0d in order", got.size(), exp_w.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [71:0] held [$];
        int n_leak;
        n_leak = 0;
        src = '{mk_start(0), mk_data(), mk_data(), mk_data(), mk_data(), mk_data(), mk_data()};
        pct = 100;
        for (int i = 0; i < 40 && m_q.size() < 3; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_fill cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (m_q.size() < 3) begin
            errors++;
            $display("FAIL rstmid_timeout buffered=%0d exp>=3", m_q.size());
        end
        held = m_q;
        held = {held, src};
        rst = 1'b1;
        step();
        rst = 1'b0;
        src.delete();
        pct = 0;
        s_valid = 1'b0;
        checks++;
        if (act_vec() !== {1'b0, IDLE_W, 8'hFF, 3'b000}) begin
            errors++;
            $display("FAIL rstmid_reset got=%h exp=%h", act_vec(), {1'b0, IDLE_W, 8'hFF, 3'b000});
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec() || vld !== ((i % 2) == 0) || txd !== IDLE_W) begin
                errors++;
                $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            foreach (held[j]) if (vld && {txc, txd} == held[j]) n_leak++;
        end
        checks++;
        if (n_leak != 0) begin
            errors++;
            $display("FAIL rstmid_leak got=%0d exp=0", n_leak);
        end
        src = '{mk_start(0), mk_data(), mk_term(4)};
        pct = 100;
        repeat (14) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_next cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int kind, n;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(5);
            n    = $urandom_range(4);
            case (kind)
                0: src.push_back(mk_start(0));
                1: src.push_back(mk_start(1));
                2: src.push_back(mk_single());
                3: src.push_back(mk_tail_start());
                default: src.push_back(mk_data());
            endcase
            if (kind != 2) begin
                for (int i = 0; i < n; i++) begin
                    src.push_back(($urandom_range(7) == 0) ? mk_start(1) : mk_data());
                end
                if (kind != 5) src.push_back(mk_term($urandom_range(7)));
            end
            pct = $urandom_range(20, 100);
            for (int i = 0; i < 400 && src.size() > 0; i++) begin
                step();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
                end
            end
            checks++;
            if (src.size() != 0) begin
                errors++;
                $display("FAIL random_timeout left=%0d exp=0", src.size());
                src.delete();
            end
            repeat ($urandom_range(5)) begin
                step();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_gap cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
                end
            end
        end
    endtask

`ifdef XGMII_TX_PACER_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        pct = 0;
        repeat (2) step();
        rst = 1'b0;
        for (int f = 0; f < 7; f++) begin
            src = '{mk_start(0), mk_data(), mk_data()};
            if (f < 5) src.push_back(mk_term(5));
            pct = 100;
            for (int i = 0; i < 40 && src.size() > 0; i++) begin
                step();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL stats cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
                end
            end
            repeat (8) step();
            if (f >= 5) begin
                src = '{mk_term(0)};
                repeat (6) step();
            end
        end
        checks++;
        if (frame_cnt !== 32'd7 || ufl_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stats_counts frames=%0d ufl=%0d exp 7/2", frame_cnt, ufl_cnt);
        end
        force dut.frame_cnt_q = '1;
        force dut.underflow_cnt_q = '1;
        step();
        release dut.frame_cnt_q;
        release dut.underflow_cnt_q;
        m_frames = '1;
        m_ufls   = '1;
        src = '{mk_start(0), mk_data()};
        pct = 100;
        repeat (16) step();
        src = '{mk_term(0)};
        repeat (8) step();
        checks++;
        if (frame_cnt !== m_frames || ufl_cnt !== m_ufls || frame_cnt !== '1) begin
            errors++;
            $display("FAIL stats_sat frames=%h ufl=%h exp all-ones", frame_cnt, ufl_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_back_to_back();
        test_underflow();
        test_protocol_err();
        test_reset_midframe();
        test_random();
`ifdef XGMII_TX_PACER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
